// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with a look-ahead pixel-request
// port and built-in test patterns; every output is registered and aligned.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 8,
  parameter int DATA_LAT = 2
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [3*CW-1:0]   pixel_data,
  output logic              data_req,
  output logic [11:0]       req_x,
  output logic [11:0]       req_y,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic [3*CW-1:0]   vga_rgb,
  output logic [11:0]       x,
  output logic [11:0]       y,
  output logic              line_start,
  output logic              frame_start
);

  localparam logic [12:0] H_SY     = 13'(H_SYNC);
  localparam logic [12:0] H_ST     = 13'(H_SYNC + H_BP);
  localparam logic [12:0] H_EN     = 13'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] H_LAST   = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [12:0] V_SY     = 13'(V_SYNC);
  localparam logic [12:0] V_ST     = 13'(V_SYNC + V_BP);
  localparam logic [12:0] V_EN     = 13'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] V_LAST   = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
  localparam logic        HS_ON    = 1'(HS_POL);
  localparam logic        VS_ON    = 1'(VS_POL);

  localparam logic [1:0] MODE_EXT   = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_GRID  = 2'd2;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } disp_t;

  localparam disp_t DISP_RST = '{de: 1'b0, hs: ~HS_ON, vs: ~VS_ON, ls: 1'b0,
                                 fs: 1'b0, x: 12'd0, y: 12'd0};

  logic [11:0]     h_q, h_d, v_q, v_d;
  logic [11:0]     bar_pix_q, bar_pix_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [1:0]      mode_q;
  disp_t           stage_d;
  disp_t           disp_q [DATA_LAT+1];
  logic [2:0]      bar_q  [DATA_LAT];
  logic [1:0]      md_q   [DATA_LAT];
  logic [3*CW-1:0] rgb_q, rgb_d;
  logic            h_act, v_act;
  disp_t           nxt;
  logic [2:0]      nxt_bar;
  logic [1:0]      nxt_md;

  always_comb begin
    h_d = (h_q == H_LAST) ? 12'd0 : h_q + 12'd1;
    v_d = v_q;
    if (h_q == H_LAST) v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
  end

  // Bar index advances every H_ACTIVE/8 pixels and restarts as each line enters the active region.
  always_comb begin
    bar_pix_d = bar_pix_q + 12'd1;
    bar_idx_d = bar_idx_q;
    if (h_d == H_ST[11:0]) begin
      bar_pix_d = 12'd0;
      bar_idx_d = 3'd0;
    end else if (bar_pix_q == BAR_LAST) begin
      bar_pix_d = 12'd0;
      bar_idx_d = bar_idx_q + 3'd1;
    end
  end

  always_comb begin
    h_act      = ({1'b0, h_q} >= H_ST) && ({1'b0, h_q} < H_EN);
    v_act      = ({1'b0, v_q} >= V_ST) && ({1'b0, v_q} < V_EN);
    stage_d    = DISP_RST;
    stage_d.de = h_act && v_act;
    stage_d.hs = ({1'b0, h_q} < H_SY) ? HS_ON : ~HS_ON;
    stage_d.vs = ({1'b0, v_q} < V_SY) ? VS_ON : ~VS_ON;
    stage_d.ls = (h_q == 12'd0);
    stage_d.fs = (h_q == 12'd0) && (v_q == 12'd0);
    if (h_act && v_act) begin
      stage_d.x = h_q - H_ST[11:0];
      stage_d.y = v_q - V_ST[11:0];
    end
  end

  assign nxt     = disp_q[DATA_LAT-1];
  assign nxt_bar = bar_q[DATA_LAT-1];
  assign nxt_md  = md_q[DATA_LAT-1];

  // The pixel is chosen from the stage about to become visible, so rgb lands with its de/x/y.
  always_comb begin
    rgb_d = '0;
    if (nxt.de) begin
      case (nxt_md)
        MODE_EXT:  rgb_d = pixel_data;
        MODE_BARS: rgb_d = {{CW{~nxt_bar[1]}}, {CW{~nxt_bar[2]}}, {CW{~nxt_bar[0]}}};
        MODE_GRID: if (nxt.x[3:0] == 4'd0 || nxt.y[3:0] == 4'd0) rgb_d = '1;
        default:   rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      h_q       <= 12'd0;
      v_q       <= 12'd0;
      bar_pix_q <= 12'd0;
      bar_idx_q <= 3'd0;
      mode_q    <= MODE_EXT;
      rgb_q     <= '0;
      for (int i = 0; i <= DATA_LAT; i++) disp_q[i] <= DISP_RST;
      for (int i = 0; i < DATA_LAT; i++) begin
        bar_q[i] <= 3'd0;
        md_q[i]  <= MODE_EXT;
      end
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
      if (h_q == 12'd0 && v_q == 12'd0) mode_q <= mode;
      disp_q[0] <= stage_d;
      bar_q[0]  <= bar_idx_q;
      md_q[0]   <= mode_q;
      for (int i = 1; i <= DATA_LAT; i++) disp_q[i] <= disp_q[i-1];
      for (int i = 1; i < DATA_LAT; i++) begin
        bar_q[i] <= bar_q[i-1];
        md_q[i]  <= md_q[i-1];
      end
      rgb_q <= rgb_d;
    end
  end

  assign data_req    = disp_q[0].de;
  assign req_x       = disp_q[0].x;
  assign req_y       = disp_q[0].y;
  assign vga_hs      = disp_q[DATA_LAT].hs;
  assign vga_vs      = disp_q[DATA_LAT].vs;
  assign vga_de      = disp_q[DATA_LAT].de;
  assign x           = disp_q[DATA_LAT].x;
  assign y           = disp_q[DATA_LAT].y;
  assign line_start  = disp_q[DATA_LAT].ls;
  assign frame_start = disp_q[DATA_LAT].fs;
  assign vga_rgb     = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a tiny 14x7 raster: timing model over
// whole frames, a table of pattern pixels, mid-frame mode change and reset.
module tb_vga_timing_gen;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [23:0] pixel_data;
  logic [23:0] src_q;
  logic        data_req;
  logic [11:0] req_x, req_y;
  logic        vga_hs, vga_vs, vga_de;
  logic [23:0] vga_rgb;
  logic [11:0] vga_x, vga_y;
  logic        line_start, frame_start;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic        hs, vs, de, ls, fs, req;
    logic [11:0] x, y, rx, ry;
    logic [23:0] rgb;
  } samp_t;

  typedef struct {
    logic [1:0]  mode;
    int          px;
    int          py;
    logic [23:0] rgb;
  } vec_t;

  samp_t       win [2*FT];
  logic [23:0] fb [4][8];
  vec_t        tbl [17];
  logic [23:0] barRgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  vga_timing_gen #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .HS_POL(0), .VS_POL(0), .CW(8), .DATA_LAT(2)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .mode(mode), .pixel_data(pixel_data),
    .data_req(data_req), .req_x(req_x), .req_y(req_y),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb),
    .x(vga_x), .y(vga_y), .line_start(line_start), .frame_start(frame_start)
  );

  always #5 sys_clk = ~sys_clk;

  // Pixel source: request issued at edge E is sampled by the DUT at edge E+2.
  always @(posedge sys_clk) src_q <= {req_x[7:0], req_y[7:0], 8'hA5};
  assign pixel_data = src_q;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " strobes/sync"},
                {26'd0, data_req, vga_de, line_start, frame_start, vga_hs, vga_vs}, 32'b000011);
    checkOutput({tag, " req xy"}, {8'd0, req_x, req_y}, 32'd0);
    checkOutput({tag, " disp xy"}, {8'd0, vga_x, vga_y}, 32'd0);
    checkOutput({tag, " rgb"}, {8'd0, vga_rgb}, 32'd0);
  endtask

  task automatic waitFrameStart(output int edges);
    edges = 0;
    do begin
      stepCycle();
      edges++;
    end while (!frame_start && edges < 2*FT);
    if (!frame_start) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL frame_start wait: none within %0d clocks, expected one", edges);
    end
  endtask

  task automatic captureWindow(input int n);
    for (int i = 0; i < n; i++) begin
      win[i] = '{hs: vga_hs, vs: vga_vs, de: vga_de, ls: line_start, fs: frame_start,
                 req: data_req, x: vga_x, y: vga_y, rx: req_x, ry: req_y, rgb: vga_rgb};
      stepCycle();
    end
  endtask

  // Independent raster model over a window that starts on a displayed frame_start.
  task automatic checkTiming(input string tag, input int n);
    int h, v, badSync, badPos, badRgb, badReq;
    int hsLow, vsLow, fsCnt, lsCnt, deCnt, reqCnt, firstReq, firstDe;
    logic eDe, eReqDe;
    logic [11:0] eX, eY, rX, rY;
    badSync = 0; badPos = 0; badRgb = 0; badReq = 0;
    hsLow = 0; vsLow = 0; fsCnt = 0; lsCnt = 0; deCnt = 0; reqCnt = 0;
    firstReq = -1; firstDe = -1;
    for (int i = 0; i < n; i++) begin
      h   = i % HT;
      v   = (i / HT) % VT;
      eDe = (h >= 4 && h < 12 && v >= 2 && v < 6);
      eX  = eDe ? 12'(h - 4) : 12'd0;
      eY  = eDe ? 12'(v - 2) : 12'd0;
      if (win[i].hs !== (h >= 2) || win[i].vs !== (v >= 1) ||
          win[i].ls !== (h == 0) || win[i].fs !== (h == 0 && v == 0)) badSync++;
      if (win[i].de !== eDe || win[i].x !== eX || win[i].y !== eY) badPos++;
      if (win[i].rgb !== (eDe ? {eX[7:0], eY[7:0], 8'hA5} : 24'h0)) badRgb++;
      if (i + 2 < n) begin
        h      = (i + 2) % HT;
        v      = ((i + 2) / HT) % VT;
        eReqDe = (h >= 4 && h < 12 && v >= 2 && v < 6);
        rX     = eReqDe ? 12'(h - 4) : 12'd0;
        rY     = eReqDe ? 12'(v - 2) : 12'd0;
        if (win[i].req !== eReqDe || win[i].rx !== rX || win[i].ry !== rY) badReq++;
      end
      if (win[i].hs == 1'b0) hsLow++;
      if (win[i].vs == 1'b0) vsLow++;
      if (win[i].fs) fsCnt++;
      if (win[i].ls) lsCnt++;
      if (win[i].de) begin
        deCnt++;
        if (firstDe < 0) firstDe = i;
      end
      if (win[i].req) begin
        reqCnt++;
        if (firstReq < 0) firstReq = i;
      end
    end
    checkOutput({tag, " sync/strobe pattern errors"}, badSync, 0);
    checkOutput({tag, " de/x/y errors"}, badPos, 0);
    checkOutput({tag, " external rgb errors"}, badRgb, 0);
    checkOutput({tag, " data_req/req_xy errors"}, badReq, 0);
    checkOutput({tag, " hs low clocks"}, hsLow, 2 * n / HT);
    checkOutput({tag, " vs low clocks"}, vsLow, 2 * HT);
    checkOutput({tag, " frame_start count"}, fsCnt, 2);
    checkOutput({tag, " line_start count"}, lsCnt, 14);
    checkOutput({tag, " de count"}, deCnt, 64);
    checkOutput({tag, " data_req count"}, reqCnt, 64);
    checkOutput({tag, " first data_req index"}, firstReq, 30);
    checkOutput({tag, " first de index"}, firstDe, 32);
    if (firstReq >= 0)
      checkOutput({tag, " first req xy"}, {8'd0, win[firstReq].rx, win[firstReq].ry}, 32'd0);
    if (firstDe >= 0)
      checkOutput({tag, " first de xy"}, {8'd0, win[firstDe].x, win[firstDe].y}, 32'd0);
  endtask

  task automatic captureFrame();
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 8; i++) fb[j][i] = 24'h5A5A5A;
    for (int i = 0; i < FT; i++) begin
      if (vga_de && vga_x < 12'd8 && vga_y < 12'd4) fb[vga_y[1:0]][vga_x[2:0]] = vga_rgb;
      stepCycle();
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m);
    int e;
    mode = m;
    waitFrameStart(e);
    waitFrameStart(e);
    captureFrame();
  endtask

  initial begin
    int e, nz, deSeen, bad;

    tbl[0]  = '{2'd0, 0, 0, 24'h0000A5};
    tbl[1]  = '{2'd0, 3, 2, 24'h0302A5};
    tbl[2]  = '{2'd0, 7, 3, 24'h0703A5};
    tbl[3]  = '{2'd1, 0, 0, 24'hFFFFFF};
    tbl[4]  = '{2'd1, 1, 0, 24'hFFFF00};
    tbl[5]  = '{2'd1, 2, 1, 24'h00FFFF};
    tbl[6]  = '{2'd1, 3, 2, 24'h00FF00};
    tbl[7]  = '{2'd1, 4, 3, 24'hFF00FF};
    tbl[8]  = '{2'd1, 5, 0, 24'hFF0000};
    tbl[9]  = '{2'd1, 6, 1, 24'h0000FF};
    tbl[10] = '{2'd1, 7, 3, 24'h000000};
    tbl[11] = '{2'd2, 0, 0, 24'hFFFFFF};
    tbl[12] = '{2'd2, 0, 2, 24'hFFFFFF};
    tbl[13] = '{2'd2, 5, 0, 24'hFFFFFF};
    tbl[14] = '{2'd2, 3, 2, 24'h000000};
    tbl[15] = '{2'd3, 0, 0, 24'h000000};
    tbl[16] = '{2'd3, 4, 2, 24'h000000};

    rst  = 1'b1;
    mode = 2'd0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    waitFrameStart(e);
    checkOutput("first frame_start latency", e, 3);
    captureWindow(2*FT);
    checkTiming("run", 2*FT);

    for (int i = 0; i < 17; i++) begin
      if (i == 0 || tbl[i].mode != tbl[i-1].mode) applyStimulus(tbl[i].mode);
      checkOutput($sformatf("mode%0d pixel(%0d,%0d)", tbl[i].mode, tbl[i].px, tbl[i].py),
                  {8'd0, fb[tbl[i].py][tbl[i].px]}, {8'd0, tbl[i].rgb});
    end

    bad = 0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 8; i++) if (fb[j][i] !== 24'h0) bad++;
    checkOutput("mode3 nonblack pixels", bad, 0);

    waitFrameStart(e);
    for (int i = 0; i < 20; i++) stepCycle();
    mode = 2'd1;
    nz = 0;
    deSeen = 0;
    for (int i = 20; i < FT; i++) begin
      if (vga_de) begin
        deSeen++;
        if (vga_rgb !== 24'h0) nz++;
      end
      stepCycle();
    end
    checkOutput("midframe next frame_start", frame_start, 1'b1);
    checkOutput("midframe old de count", deSeen, 32);
    checkOutput("midframe old pattern kept", nz, 0);
    captureFrame();
    bad = 0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 8; i++) if (fb[j][i] !== barRgb[i]) bad++;
    checkOutput("midframe new bars pixel errors", bad, 0);

    mode = 2'd0;
    e = 0;
    while (!vga_de && e < 2*FT) begin
      stepCycle();
      e++;
    end
    checkOutput("active line reached before reset pulse", vga_de, 1'b1);
    for (int i = 0; i < 3; i++) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkResetOutputs("midline reset");
    waitFrameStart(e);
    checkOutput("frame_start latency after midline reset", e, 3);
    captureWindow(2*FT);
    checkTiming("after reset", 2*FT);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
